// File: rtl/lvds_rx_clk_aligner_if.sv
// Clock-lane word and alignment status between the deserializer, the aligner and the capture logic.
interface lvds_rx_clk_aligner_if #(
  parameter int DATA_W = 7,
  parameter int SLIP_W = 4
);
  logic              pll_locked;
  logic              restart;
  logic [DATA_W-1:0] rx_word;
  logic              bitslip;
  logic              aligned;
  logic              align_err;
  logic [DATA_W-1:0] word_out;
  logic              word_valid;
  logic [SLIP_W-1:0] slip_cnt;
  logic [7:0]        relock_cnt;

  // master: deserializer/capture side, slave: the aligner
  modport master (output pll_locked, restart, rx_word,
                  input  bitslip, aligned, align_err, word_out, word_valid, slip_cnt, relock_cnt);
  modport slave  (input  pll_locked, restart, rx_word,
                  output bitslip, aligned, align_err, word_out, word_valid, slip_cnt, relock_cnt);
endinterface

// File: rtl/lvds_rx_clk_aligner.sv
// Bitslips the LVDS clock-lane deserializer until its word matches the training pattern,
// declares lock after LOCK_COUNT consecutive matches and drops it after UNLOCK_COUNT misses.
module lvds_rx_clk_aligner #(
  parameter int                DATA_W        = 7,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = 7'b1100011,
  parameter int                SLIP_WAIT     = 4,
  parameter int                LOCK_COUNT    = 16,
  parameter int                UNLOCK_COUNT  = 4,
  parameter int                MAX_SLIPS     = 14
) (
  input logic                  refclk,
  input logic                  rst,
  lvds_rx_clk_aligner_if.slave bus
);
  localparam int SW = $clog2(MAX_SLIPS + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_COUNT + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);

  typedef enum logic [2:0] {IDLE, SEARCH, SLIP, SETTLE, CONFIRM, LOCKED, FAIL} state_t;
  state_t state, state_nx;

  logic [1:0]        lk_sync;
  logic              lk_s;
  logic              match_w;
  logic [SW-1:0]     slip_q, slip_nx;
  logic [MW-1:0]     match_q, match_nx;
  logic [UW-1:0]     miss_q, miss_nx;
  logic [WW-1:0]     wait_q, wait_nx;
  logic              relock_inc;
  logic              bitslip_q, aligned_q, err_q;
  logic [DATA_W-1:0] word_q;
  logic [7:0]        relock_q;

  assign lk_s    = lk_sync[1];
  assign match_w = (bus.rx_word == TRAIN_PATTERN);

  always_comb begin
    state_nx   = state;
    slip_nx    = slip_q;
    match_nx   = match_q;
    miss_nx    = miss_q;
    wait_nx    = wait_q;
    relock_inc = 1'b0;
    // restart and PLL loss pre-empt everything; in IDLE this simply holds IDLE
    if (bus.restart || !lk_s) begin
      state_nx = IDLE;
      slip_nx  = '0;
      match_nx = '0;
      miss_nx  = '0;
      wait_nx  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = SEARCH;
          slip_nx  = '0;
        end
        SEARCH: begin
          if (match_w) begin
            state_nx = CONFIRM;
            match_nx = MW'(1);
          end else if (slip_q == SW'(MAX_SLIPS)) begin
            state_nx = FAIL;
          end else begin
            state_nx = SLIP;
            slip_nx  = slip_q + SW'(1);
          end
        end
        SLIP: begin
          state_nx = SETTLE;
          wait_nx  = WW'(SLIP_WAIT);
        end
        SETTLE: begin
          wait_nx = wait_q - WW'(1);
          if (wait_q <= WW'(1)) begin
            state_nx = SEARCH;
            wait_nx  = '0;
          end
        end
        CONFIRM: begin
          if (match_w) begin
            if (match_q >= MW'(LOCK_COUNT - 1)) begin
              state_nx = LOCKED;
              match_nx = '0;
            end else begin
              match_nx = match_q + MW'(1);
            end
          end else begin
            match_nx = '0;
            if (slip_q == SW'(MAX_SLIPS)) begin
              state_nx = FAIL;
            end else begin
              state_nx = SLIP;
              slip_nx  = slip_q + SW'(1);
            end
          end
        end
        LOCKED: begin
          if (match_w) begin
            miss_nx = '0;
          end else if (miss_q >= UW'(UNLOCK_COUNT - 1)) begin
            state_nx   = SEARCH;
            miss_nx    = '0;
            slip_nx    = '0;
            relock_inc = 1'b1;
          end else begin
            miss_nx = miss_q + UW'(1);
          end
        end
        FAIL:    state_nx = FAIL;
        default: state_nx = IDLE;
      endcase
    end
  end

  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lk_sync   <= '0;
      state     <= IDLE;
      slip_q    <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      wait_q    <= '0;
      bitslip_q <= 1'b0;
      aligned_q <= 1'b0;
      err_q     <= 1'b0;
      word_q    <= '0;
      relock_q  <= '0;
    end else begin
      lk_sync   <= {lk_sync[0], bus.pll_locked};
      state     <= state_nx;
      slip_q    <= slip_nx;
      match_q   <= match_nx;
      miss_q    <= miss_nx;
      wait_q    <= wait_nx;
      bitslip_q <= (state_nx == SLIP);
      aligned_q <= (state_nx == LOCKED);
      err_q     <= (state_nx == FAIL);
      word_q    <= bus.rx_word;
      if (relock_inc && relock_q != 8'hff) relock_q <= relock_q + 8'd1;
    end
  end

  assign bus.bitslip    = bitslip_q;
  assign bus.aligned    = aligned_q;
  assign bus.align_err  = err_q;
  assign bus.word_out   = word_q;
  assign bus.word_valid = aligned_q;
  assign bus.slip_cnt   = slip_q;
  assign bus.relock_cnt = relock_q;
endmodule

// File: tb/tb_lvds_rx_clk_aligner.sv
// Scoreboard bench: a rotating-word deserializer model drives the aligner and expected
// slip/lock/unlock/error events are queued up front, then matched by a negedge monitor.
module tb_lvds_rx_clk_aligner;
  localparam int         DATA_W       = 7;
  localparam int         SLIP_W       = 4;
  localparam logic [6:0] TRAIN        = 7'b1100011;
  localparam int         SLIP_WAIT    = 4;
  localparam int         LOCK_COUNT   = 16;
  localparam int         UNLOCK_COUNT = 4;
  localparam int         MAX_SLIPS    = 14;
  localparam int         SYNC         = 2;              // pll_locked synchronizer depth
  localparam int         PERIOD       = SLIP_WAIT + 2;  // sample + pulse + settle per attempt

  typedef enum {EV_SLIP, EV_LOCK, EV_UNLOCK, EV_ERR, EV_ERRCLR} ev_kind_t;
  typedef struct { ev_kind_t kind; int at; int slips; int relocks; } ev_t;

  logic refclk = 1'b0;
  logic rst    = 1'b0;
  lvds_rx_clk_aligner_if #(.DATA_W(DATA_W), .SLIP_W(SLIP_W)) bus ();

  lvds_rx_clk_aligner #(
    .DATA_W(DATA_W), .TRAIN_PATTERN(TRAIN), .SLIP_WAIT(SLIP_WAIT),
    .LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT), .MAX_SLIPS(MAX_SLIPS)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .bus(bus)
  );

  always #5 refclk = ~refclk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  ev_t        exp_q[$];
  int         off;       // deserializer bit offset: slips still needed to see TRAIN
  int         mode;      // 0: rotated pattern, 1: never-matching junk, 2: words set by caller
  int         relocks;   // expected relock_cnt
  logic [6:0] last_word;
  logic       wo_ok;
  logic       prev_bs, prev_al, prev_er;

  always @(posedge refclk) cyc <= cyc + 1;

  always @(posedge refclk or posedge rst)
    if (rst) wo_ok <= 1'b0;
    else begin
      last_word <= bus.rx_word;
      wo_ok     <= 1'b1;
    end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] rot(input int k);
    logic [13:0] d;
    d = {TRAIN, TRAIN} << k;
    return d[13:7];
  endfunction

  function automatic logic [6:0] junk();
    logic [6:0] w;
    w = 7'($urandom);
    if (w == TRAIN) w = ~w;
    return w;
  endfunction

  task automatic push(input ev_kind_t k, input int at, input int slips, input int rl);
    ev_t e;
    e.kind = k; e.at = at; e.slips = slips; e.relocks = rl;
    exp_q.push_back(e);
  endtask

  // pll_locked raised at cycle m with the word k slips away from TRAIN
  task automatic expect_lock(input int m, input int k);
    for (int i = 1; i <= k; i++) push(EV_SLIP, m + SYNC + 2 + PERIOD * (i - 1), i, -1);
    push(EV_LOCK, m + SYNC + 1 + PERIOD * k + LOCK_COUNT, k, relocks);
  endtask

  task automatic see(input ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got %s at cycle %0d want none", k.name(), cyc);
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("event_kind(%s)", e.kind.name()), int'(k), int'(e.kind));
    if (e.at >= 0)      chk($sformatf("%s_cycle", k.name()), cyc, e.at);
    if (e.slips >= 0)   chk($sformatf("%s_slip_cnt", k.name()), int'(bus.slip_cnt), e.slips);
    if (e.relocks >= 0) chk($sformatf("%s_relock_cnt", k.name()), int'(bus.relock_cnt), e.relocks);
    if (k == EV_LOCK)   chk("word_valid_on_lock", int'(bus.word_valid), 1);
    if (k == EV_UNLOCK) chk("word_valid_on_unlock", int'(bus.word_valid), 0);
  endtask

  always @(negedge refclk) begin
    if (rst) begin
      prev_bs <= 1'b0; prev_al <= 1'b0; prev_er <= 1'b0;
    end else begin
      if (wo_ok)                       chk("word_out", int'(bus.word_out), int'(last_word));
      if (bus.bitslip)                 chk("bitslip_single_cycle", int'(prev_bs), 0);
      if (bus.bitslip && !prev_bs)     see(EV_SLIP);
      if (bus.aligned && !prev_al)     see(EV_LOCK);
      if (!bus.aligned && prev_al)     see(EV_UNLOCK);
      if (bus.align_err && !prev_er)   see(EV_ERR);
      if (!bus.align_err && prev_er)   see(EV_ERRCLR);
      prev_bs <= bus.bitslip; prev_al <= bus.aligned; prev_er <= bus.align_err;
    end
  end

  task automatic step();
    @(negedge refclk);
    if (bus.bitslip) off = (off + 6) % 7;
    if (mode == 0)      bus.rx_word = rot(off);
    else if (mode == 1) bus.rx_word = junk();
  endtask

  task automatic drain(input string name, input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) step();
    chk({name, "_pending_events"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic lock_trial(input int k);
    int m;
    off = k; mode = 0;
    step(); m = cyc; bus.pll_locked = 1'b1;
    expect_lock(m, k);
    drain("lock", 120);
  endtask

  task automatic teardown();
    int d;
    step(); d = cyc; bus.pll_locked = 1'b0;
    push(EV_UNLOCK, d + SYNC + 1, 0, relocks);
    drain("pll_drop", 20);
    repeat (2) step();
  endtask

  task automatic unlock_trial();
    logic [6:0] w[$];
    int run, hit, c, n;
    w = {junk(), junk(), junk(), TRAIN};
    n = $urandom_range(0, 12);
    for (int i = 0; i < n; i++) w.push_back(($urandom_range(0, 1) == 1) ? TRAIN : junk());
    repeat (UNLOCK_COUNT) w.push_back(junk());
    run = 0; hit = -1;
    foreach (w[i]) if (hit < 0) begin
      run = (w[i] == TRAIN) ? 0 : run + 1;
      if (run == UNLOCK_COUNT) hit = i;
    end
    relocks = (relocks < 255) ? relocks + 1 : 255;
    step(); c = cyc; mode = 2;
    push(EV_UNLOCK, c + hit + 1, 0, relocks);
    push(EV_LOCK, c + hit + 1 + LOCK_COUNT, 0, relocks);
    for (int i = 0; i <= hit; i++) begin
      if (i > 0) step();
      bus.rx_word = w[i];
    end
    mode = 0; off = 0;
    drain("relock", 60);
  endtask

  task automatic fail_trial();
    int m, r, k;
    mode = 1;
    step(); m = cyc; bus.pll_locked = 1'b1;
    for (int i = 1; i <= MAX_SLIPS; i++) push(EV_SLIP, m + SYNC + 2 + PERIOD * (i - 1), i, -1);
    push(EV_ERR, m + SYNC + 2 + PERIOD * MAX_SLIPS, MAX_SLIPS, -1);
    drain("fail", 150);
    repeat (20) step();
    chk("bitslip_in_fail", int'(bus.bitslip), 0);
    k = $urandom_range(0, 6); off = k; mode = 0;
    step(); r = cyc; bus.restart = 1'b1;
    push(EV_ERRCLR, r + 1, 0, -1);
    expect_lock(r - 1, k);   // IDLE is reached one cycle sooner than from a pll_locked rise
    step(); bus.restart = 1'b0;
    drain("restart", 120);
  endtask

  task automatic pll_drop_trial();
    int m, q;
    off = $urandom_range(2, 6); mode = 0;
    step(); m = cyc; bus.pll_locked = 1'b1;
    push(EV_SLIP, m + SYNC + 2, 1, -1);
    while (cyc < m + SYNC + 4) step();
    bus.pll_locked = 1'b0;
    while (cyc < m + SYNC + 7) step();
    chk("slip_cnt_after_pll_loss", int'(bus.slip_cnt), 0);
    chk("bitslip_after_pll_loss", int'(bus.bitslip), 0);
    chk("settle_drop_pending_events", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) step();
    step(); q = cyc; bus.pll_locked = 1'b1;
    expect_lock(q, off);
    drain("relock_after_pll", 120);
  endtask

  task automatic rst_trial();
    int m, r;
    off = $urandom_range(1, 6); mode = 0;
    step(); m = cyc; bus.pll_locked = 1'b1;
    push(EV_SLIP, m + SYNC + 2, 1, -1);
    while (cyc < m + SYNC + 2) step();
    chk("bitslip_before_rst", int'(bus.bitslip), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_bitslip", int'(bus.bitslip), 0);
    chk("rst_aligned", int'(bus.aligned), 0);
    chk("rst_align_err", int'(bus.align_err), 0);
    chk("rst_relock_cnt", int'(bus.relock_cnt), 0);
    relocks = 0;
    repeat (2) step();
    step(); r = cyc; rst = 1'b0;
    expect_lock(r, off);
    drain("lock_after_rst", 120);
  endtask

  initial begin
    bus.pll_locked = 1'b0; bus.restart = 1'b0; bus.rx_word = '0;
    off = 0; mode = 0; relocks = 0;
    #1 rst = 1'b1;
    repeat (3) @(negedge refclk);
    chk("reset_bitslip",    int'(bus.bitslip), 0);
    chk("reset_aligned",    int'(bus.aligned), 0);
    chk("reset_align_err",  int'(bus.align_err), 0);
    chk("reset_word_out",   int'(bus.word_out), 0);
    chk("reset_word_valid", int'(bus.word_valid), 0);
    chk("reset_slip_cnt",   int'(bus.slip_cnt), 0);
    chk("reset_relock_cnt", int'(bus.relock_cnt), 0);
    rst = 1'b0;
    repeat (2) step();

    lock_trial(0);
    unlock_trial();
    teardown();
    lock_trial(3);
    teardown();
    repeat (3) begin
      lock_trial($urandom_range(1, 6));
      teardown();
    end
    fail_trial();
    teardown();
    pll_drop_trial();
    teardown();
    rst_trial();
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
